// File: rtl/ir_frame_decoder.sv
// rtl/ir_frame_decoder.sv - pulse-distance IR frame decoder.
// Define IR_REPEAT_EN to decode repeat codes. Without it, a short leader space is an error.
module ir_frame_decoder #(
  parameter int TICK_DIV         = 1024,
  parameter int FRAME_BITS       = 32,
  parameter int LEADER_MARK_MIN  = 80,
  parameter int LEADER_SPACE_MIN = 38,
  parameter int REPEAT_SPACE_MIN = 18,
  parameter int BIT_THRESH       = 11,
  parameter int TIMEOUT_TICKS    = 120
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_ir_signal,
  output logic [FRAME_BITS-1:0] o_frame,
  output logic                  o_valid,
  output logic                  o_repeat,
  output logic                  o_error,
  output logic                  o_busy
);

  localparam int DW = $clog2(TIMEOUT_TICKS + 1);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = $clog2(FRAME_BITS + 1);

`ifdef IR_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK
  } state_t;

  state_t                state, state_n;
  logic [1:0]            sync_q;
  logic                  ir_prev;
  logic [TW-1:0]         tick_cnt;
  logic [DW-1:0]         dur;
  logic [BW-1:0]         bit_cnt;
  logic [FRAME_BITS-1:0] shreg;
  logic                  rep_mode, rep_mode_n;
  logic                  clr_bits, shift_en, load_frame, rep_pulse, err_pulse;
  logic                  valid_q, repeat_q, error_q;

  wire ir_s     = sync_q[1];
  wire rise     = ir_s & ~ir_prev;
  wire fall     = ~ir_s & ir_prev;
  wire tick     = (tick_cnt == TW'(TICK_DIV - 1));
  wire timeout  = (dur == DW'(TIMEOUT_TICKS));
  wire last_bit = (bit_cnt == BW'(FRAME_BITS - 1));
  wire bit_val  = (dur >= DW'(BIT_THRESH));

  always_comb begin
    state_n    = state;
    rep_mode_n = rep_mode;
    clr_bits   = 1'b0;
    shift_en   = 1'b0;
    load_frame = 1'b0;
    rep_pulse  = 1'b0;
    err_pulse  = 1'b0;
    // A saturated duration aborts before any edge in the same cycle is considered.
    if (timeout && state != IDLE && state != LEAD_MARK) begin
      err_pulse = 1'b1;
      state_n   = IDLE;
    end else begin
      case (state)
        IDLE:      if (rise) state_n = LEAD_MARK;
        LEAD_MARK: begin
          if (timeout) state_n = IDLE;
          else if (fall) state_n = (dur >= DW'(LEADER_MARK_MIN)) ? LEAD_SPACE : IDLE;
        end
        LEAD_SPACE: if (rise) begin
          if (dur >= DW'(LEADER_SPACE_MIN)) begin
            state_n    = BIT_MARK;
            clr_bits   = 1'b1;
            rep_mode_n = 1'b0;
          end else if (REP_EN && dur >= DW'(REPEAT_SPACE_MIN)) begin
            state_n    = STOP_MARK;
            rep_mode_n = 1'b1;
          end else begin
            err_pulse = 1'b1;
            state_n   = IDLE;
          end
        end
        BIT_MARK:  if (fall) state_n = BIT_SPACE;
        BIT_SPACE: if (rise) begin
          shift_en = 1'b1;
          state_n  = last_bit ? STOP_MARK : BIT_MARK;
        end
        STOP_MARK: if (fall) begin
          state_n = IDLE;
          if (rep_mode) rep_pulse = 1'b1;
          else          load_frame = 1'b1;
        end
        default:   state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state    <= IDLE;
      sync_q   <= '0;
      ir_prev  <= 1'b0;
      tick_cnt <= '0;
      dur      <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      rep_mode <= 1'b0;
      o_frame  <= '0;
      valid_q  <= 1'b0;
      repeat_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state    <= state_n;
      rep_mode <= rep_mode_n;
      sync_q   <= {sync_q[0], i_ir_signal};
      ir_prev  <= ir_s;
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      // Edge clears win over a coincident tick; the FSM already saw the old duration.
      if (rise || fall)
        dur <= '0;
      else if (tick && !timeout)
        dur <= dur + DW'(1);
      if (clr_bits) begin
        bit_cnt <= '0;
        shreg   <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + BW'(1);
        shreg   <= {bit_val, shreg[FRAME_BITS-1:1]};
      end
      if (load_frame) o_frame <= shreg;
      valid_q  <= load_frame;
      repeat_q <= rep_pulse;
      error_q  <= err_pulse;
    end
  end

  assign o_valid  = valid_q;
  assign o_repeat = repeat_q;
  assign o_error  = error_q;
  assign o_busy   = (state != IDLE);

endmodule

// File: tb/tb_ir_frame_decoder.sv
// tb/tb_ir_frame_decoder.sv - scoreboard bench for ir_frame_decoder with randomized pulse timing.
module tb_ir_frame_decoder;

  localparam int TD = 4;
  localparam int K_VALID = 0, K_REPEAT = 1, K_ERROR = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ir;
  logic [31:0] frame;
  logic        valid, rep, err, busy;

  typedef struct {int kind; logic [31:0] frame;} exp_t;
  exp_t        q[$];
  exp_t        mon_e;
  int          mon_kind;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] last_frame = 32'h0;

  always #5 clk = ~clk;

  ir_frame_decoder #(.TICK_DIV(TD)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_ir_signal(ir),
    .o_frame(frame), .o_valid(valid), .o_repeat(rep), .o_error(err), .o_busy(busy)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && (valid || rep || err)) begin
      mon_kind = valid ? K_VALID : (rep ? K_REPEAT : K_ERROR);
      check("pulse_one_hot", 64'(int'(valid) + int'(rep) + int'(err)), 64'd1);
      if (q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_pulse: got kind %0d frame %h want no pulse at %0t", mon_kind, frame, $time);
      end else begin
        mon_e = q.pop_front();
        check("pulse_kind", 64'(mon_kind), 64'(mon_e.kind));
        check("pulse_frame", 64'(frame), 64'(mon_e.frame));
      end
    end
  end

  task automatic hold(input logic lvl, input int ticks);
    ir = lvl;
    repeat (ticks * TD) @(posedge clk);
  endtask

  task automatic send_bits(input logic [31:0] v, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      hold(1'b1, $urandom_range(6, 4));
      hold(1'b0, v[i] ? $urandom_range(17, 15) : $urandom_range(6, 4));
    end
  endtask

  task automatic send_frame(input logic [31:0] v, input int gap);
    q.push_back('{K_VALID, v});
    last_frame = v;
    hold(1'b1, 88);
    hold(1'b0, 44);
    send_bits(v, 32);
    hold(1'b1, 5);
    hold(1'b0, gap);
  endtask

  task automatic idle_check(input string name);
    @(negedge clk);
    check({name, "_drained"}, 64'(q.size()), 64'd0);
    check({name, "_busy"}, 64'(busy), 64'd0);
    check({name, "_frame"}, 64'(frame), 64'(last_frame));
  endtask

  initial begin
    logic [31:0] rv;
    rst_n = 1'b0;
    ir    = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset_frame", 64'(frame), 64'd0);
    check("reset_pulses", 64'({valid, rep, err}), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    hold(1'b0, 10);

    send_frame(32'h00FF_A25D, 30);
    idle_check("basic");

    hold(1'b1, 40);
    hold(1'b0, 30);
    idle_check("noise");

    q.push_back('{K_ERROR, last_frame});
    hold(1'b1, 88);
    hold(1'b0, 44);
    send_bits(32'h0000_0155, 9);
    hold(1'b1, 5);
    hold(1'b0, 135);
    idle_check("timeout");

`ifdef IR_REPEAT_EN
    q.push_back('{K_REPEAT, last_frame});
`else
    q.push_back('{K_ERROR, last_frame});
`endif
    hold(1'b1, 88);
    hold(1'b0, 22);
    hold(1'b1, 5);
    hold(1'b0, 30);
    idle_check("repeat");

    hold(1'b1, 88);
    hold(1'b0, 44);
    send_bits(32'hDEAD_BEEF, 20);
    hold(1'b1, 3);
    rst_n = 1'b0;
    ir    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("midreset_frame", 64'(frame), 64'd0);
    check("midreset_busy", 64'(busy), 64'd0);
    last_frame = 32'h0;
    rst_n = 1'b1;
    hold(1'b0, 10);
    send_frame(32'h1234_5678, 30);
    idle_check("after_reset");

    send_frame(32'hA5A5_5A5A, 20);
    send_frame(32'h0F0F_F0F0, 30);
    idle_check("back_to_back");

    for (int n = 0; n < 5; n++) begin
      rv = $urandom;
      send_frame(rv, $urandom_range(30, 20));
    end
    idle_check("random");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
